// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues word reads, buffers in-order responses in a
// small queue, predecodes the immediate format, and flushes on redirect.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QDEPTH          = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  instr_immsrc
);

  localparam int          PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW    = $clog2(QDEPTH + 1);
  localparam int          OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] MAXO  = 32'(MAX_OUTSTANDING);
  localparam logic [31:0] DEPTH = 32'(QDEPTH);

  function automatic logic [1:0] predecode(input logic [6:0] opcode);
    case (opcode)
      7'b0100011: predecode = 2'b01;
      7'b1100011: predecode = 2'b10;
      7'b1101111: predecode = 2'b11;
      default:    predecode = 2'b00;
    endcase
  endfunction

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [1:0]    q_imm_q   [QDEPTH];

  logic        pop, push, accept, issue;
  logic [31:0] live, need, redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign pop      = instr_valid & instr_ready;
  assign push     = imem_resp_valid & (discard_q == '0) & ~redirect_valid;

  // Reserve a queue slot for every live in-flight response before issuing.
  assign live  = 32'(outst_q) - 32'(discard_q);
  assign need  = live + 32'(count_q) - {31'b0, pop};
  assign issue = (32'(outst_q) < MAXO) && (need < DEPTH);

  assign imem_req_valid = reset_n & issue & ~redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign instr_valid  = reset_n & (count_q != '0);
  assign instr        = instr_valid ? q_instr_q[rd_ptr_q] : 32'd0;
  assign instr_pc     = instr_valid ? q_pc_q[rd_ptr_q]    : 32'd0;
  assign instr_immsrc = instr_valid ? q_imm_q[rd_ptr_q]   : 2'b00;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (accept && !imem_resp_valid)      outst_d = outst_q + 1'b1;
    else if (!accept && imem_resp_valid) outst_d = outst_q - 1'b1;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is already dropped, so it is
      // not counted again in the discard budget.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      discard_d  = imem_resp_valid ? outst_q - 1'b1 : outst_q;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid && discard_q != '0) discard_d = discard_q - 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_q[wr_ptr_q] <= imem_resp_data;
      q_pc_q[wr_ptr_q]    <= resp_pc_q;
      q_imm_q[wr_ptr_q]   <= predecode(imem_resp_data[6:0]);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order, fixed-latency memory model.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset_n, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instr, instr_pc;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [1:0]  instr_immsrc;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(32'h0), .QDEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_immsrc(instr_immsrc)
  );

  typedef struct { logic [31:0] word; logic [1:0] imm; } vec_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  localparam int NV = 9;
  vec_t  vecs [NV];
  pend_t pend [$];

  int          cyc, lat, ncheck, npass;
  logic        acc_s, rsp_s, pop_s;
  logic [31:0] addr_s, pcpop_s, wpop_s;
  logic [1:0]  immpop_s;
  logic [31:0] got_pc [$];
  logic [31:0] got_w [$];
  logic [1:0]  got_imm [$];

  // Table words live at 0x200; everything else is an I-type word tagged with its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    if (a >= 32'h200 && a < 32'h200 + 32'(4 * NV)) begin
      idx = int'((a - 32'h200) >> 2);
      return vecs[idx].word;
    end
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic settle();
    if (reset_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
    end
    #1;
    acc_s    = imem_req_valid & imem_req_ready;
    addr_s   = imem_req_addr;
    rsp_s    = imem_resp_valid;
    pop_s    = instr_valid & instr_ready;
    pcpop_s  = instr_pc;
    wpop_s   = instr;
    immpop_s = instr_immsrc;
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset_n) pend.delete();
    else begin
      if (acc_s) pend.push_back('{addr: addr_s, due: cyc + lat});
      if (rsp_s) pend.delete(0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    settle();
    adv();
    settle();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_immsrc", {30'b0, instr_immsrc}, 32'd0);
    adv();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic collect(input int n, input int budget);
    got_pc.delete(); got_w.delete(); got_imm.delete();
    for (int i = 0; i < budget && got_pc.size() < n; i++) begin
      settle();
      if (pop_s) begin
        got_pc.push_back(pcpop_s);
        got_w.push_back(wpop_s);
        got_imm.push_back(immpop_s);
      end
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc, gotreq, gotins;
    logic [31:0] first_req, first_pc, first_w;
    ncheck = 0; npass = 0; cyc = 0; lat = 1;
    reset_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
    vecs[0] = '{32'h0000_0013, 2'b00};
    vecs[1] = '{32'h0011_2023, 2'b01};
    vecs[2] = '{32'h0020_8463, 2'b10};
    vecs[3] = '{32'h0080_006F, 2'b11};
    vecs[4] = '{32'h0000_0067, 2'b00};
    vecs[5] = '{32'h0001_2083, 2'b00};
    vecs[6] = '{32'h0000_00B7, 2'b00};
    vecs[7] = '{32'h0000_0097, 2'b00};
    vecs[8] = '{32'h0020_81B3, 2'b00};
    @(negedge clk);

    // Streaming with 1-cycle memory
    do_reset();
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t1_req_addr", imem_req_addr, 32'(4 * k));
      if (k < 2) chk("t1_fill_valid", {31'b0, instr_valid}, 32'd0);
      else begin
        chk("t1_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr_pc", instr_pc, 32'(4 * (k - 2)));
        chk("t1_instr", instr, mem_word(32'(4 * (k - 2))));
      end
      adv();
    end

    // Back-pressure: decode stalled for 10 cycles
    do_reset();
    instr_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (acc_s) begin
        chk("t2_acc_addr", addr_s, 32'(4 * nacc));
        nacc++;
      end
      adv();
    end
    settle();
    chk("t2_accepted", 32'(nacc), 32'd2);
    chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_head_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    collect(4, 20);
    chk("t2_pop_count", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < got_pc.size(); i++) chk("t2_pop_pc", got_pc[i], 32'(4 * i));

    // Redirect with two slow responses in flight
    do_reset();
    lat = 3;
    settle(); chk("t3_acc0", addr_s, 32'h0); adv();
    settle(); chk("t3_acc1", addr_s, 32'h4); adv();
    settle(); chk("t3_full_outst", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    settle(); chk("t3_redir_noreq", {31'b0, imem_req_valid}, 32'd0);
    adv();
    redirect_valid = 1'b0;
    gotreq = 0; gotins = 0; first_req = 32'd0; first_pc = 32'd0; first_w = 32'd0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (acc_s && gotreq == 0) begin first_req = addr_s; gotreq = 1; end
      if (instr_valid && gotins == 0) begin first_pc = instr_pc; first_w = instr; gotins = 1; end
      adv();
    end
    chk("t3_got_req", 32'(gotreq), 32'd1);
    chk("t3_first_req", first_req, 32'h100);
    chk("t3_got_instr", 32'(gotins), 32'd1);
    chk("t3_first_pc", first_pc, 32'h100);
    chk("t3_first_instr", first_w, mem_word(32'h100));

    // Redirect coinciding with a pop and a response
    do_reset();
    lat = 1;
    for (int k = 0; k < 4; k++) begin settle(); adv(); end
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    settle();
    chk("t5_pop_in_redir", {31'b0, pop_s}, 32'd1);
    chk("t5_resp_in_redir", {31'b0, rsp_s}, 32'd1);
    chk("t5_pop_pc", pcpop_s, 32'h8);
    chk("t5_redir_noreq", {31'b0, imem_req_valid}, 32'd0);
    adv();
    redirect_valid = 1'b0;
    settle();
    chk("t5_empty_n1", {31'b0, instr_valid}, 32'd0);
    chk("t5_req_n1", {31'b0, imem_req_valid}, 32'd1);
    chk("t5_addr_n1", imem_req_addr, 32'h400);
    adv();
    settle(); chk("t5_empty_n2", {31'b0, instr_valid}, 32'd0); adv();
    settle();
    chk("t5_valid_n3", {31'b0, instr_valid}, 32'd1);
    chk("t5_pc_n3", instr_pc, 32'h400);
    adv();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    settle(); adv();
    redirect_valid = 1'b0;
    collect(4, 20);
    chk("t6_pop_count", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < got_pc.size(); i++) begin
      chk("t6_wrap_pc", got_pc[i], 32'hFFFF_FFF8 + 32'(4 * i));
      chk("t6_wrap_instr", got_w[i], mem_word(32'hFFFF_FFF8 + 32'(4 * i)));
    end

    // Reset in the middle of streaming
    reset_n = 1'b0;
    settle();
    chk("t6_rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    adv();
    reset_n = 1'b1; cyc = 0;
    settle();
    chk("t6_restart_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_restart_req", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    adv();
    settle(); chk("t6_restart_addr1", imem_req_addr, 32'h4); adv();
    settle(); chk("t6_restart_pc", instr_pc, 32'h0); adv();

    // Predecode table
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle(); adv();
    redirect_valid = 1'b0;
    collect(NV, 40);
    chk("t4_pop_count", 32'(got_pc.size()), 32'(NV));
    for (int i = 0; i < NV; i++) begin
      if (i < got_pc.size()) begin
        chk("t4_pc", got_pc[i], 32'h200 + 32'(4 * i));
        chk("t4_instr", got_w[i], vecs[i].word);
        chk("t4_immsrc", {30'b0, got_imm[i]}, {30'b0, vecs[i].imm});
      end
    end

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
